bdu_bit_streamer: RTL
=====================

Name: bdu_bit_streamer

Overview:
- Transmit side of the BDU bit-serial interface.
- Accepts one query point and one reference point (x, y, z; B bits each) through a valid/ready load handshake.
- Serializes both points MSB-first, interleaving axes x, y, z per bit-plane, and drives the BDU's valid/q_bit/r_bit/code/b inputs.
- Stops streaming early when the BDU asserts terminate, reports the outcome, and returns ready for the next reference point.

Parameters:
- B, 32, coordinate width in bits; also the number of bit-planes per point.
- BW, $clog2(B), width of the b output.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- load_valid  in  1  q_*/r_* inputs hold a point pair to stream.
- load_ready  out  1  streamer can accept a point pair.
- q_x, q_y, q_z  in  B each  query coordinates.
- r_x, r_y, r_z  in  B each  reference coordinates.
- terminate  in  1  BDU early-termination flag; sampled only while valid=1.
- valid  out  1  q_bit/r_bit/code/b carry a live bit this cycle.
- q_bit  out  1  current query bit.
- r_bit  out  1  current reference bit.
- code  out  2  axis tag: 01=x, 10=y, 11=z, 00=idle.
- b  out  BW  1-based plane count, modulo 2^BW.
- point_complete  out  1  one-cycle pulse: all 3B bits were sent without termination.
- point_aborted  out  1  one-cycle pulse: stream was cut short by terminate.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs 0 except load_ready=1.
  - Captured coordinate registers and counters are cleared.
  - A reset mid-stream drops the point immediately and emits no pulses.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, valid=0, code=00, q_bit=r_bit=0, b=0.
  - Handshake when load_valid & load_ready at a rising edge:
    - Capture all six coordinates.
    - Set plane=0, axis=0.
    - Move to STREAM.
    - At that same edge, outputs take the first bit: valid=1, code=01, q_bit=q_x[B-1], r_bit=r_x[B-1], b=1.
- STREAM:
  - load_ready=0; valid=1.
  - The bit shown is from the axis selected by axis (0→x/01, 1→y/10, 2→z/11) at index B-1-plane.
  - b = (plane+1) mod 2^BW. For B=32, BW=5, so the final plane shows b=0; this wrap is intended.
  - Each edge with terminate=0 advances axis 0→1→2. On the 2→0 wrap, plane increments.
  - Full stream length is exactly 3B valid cycles.
- Normal completion:
  - At the edge ending the last bit (axis=2, plane=B-1) with terminate=0:
    - State goes to IDLE; valid=0, code=00.
    - point_complete=1 for exactly one cycle.
    - load_ready=1 in that same cycle.
- Early termination:
  - At any edge in STREAM where terminate=1:
    - State goes to IDLE; valid=0.
    - point_aborted=1 for one cycle; load_ready=1.
    - No further bits of that point are sent.
  - terminate=1 on the last bit → point_aborted, not point_complete (terminate wins).
- terminate is ignored in IDLE.
- load_valid is ignored in STREAM. The captured values are not disturbed by input changes mid-stream.
- Back-to-back points: a load accepted in the cycle a complete/abort pulse is high starts the next stream at that edge. Minimum gap between streams is one idle cycle.
- point_complete and point_aborted are never high together.

Test Plan:
- Sanity, B=32: load q=(0000FFFF, 0000FFFF, 0000FFFF), r=(0000FF00, 0000FF00, 0000FF00), terminate=0 → 96 valid cycles with code sequence 01,10,11 repeating. q_bit=0 for planes 1–16, 1 after. r_bit=1 only for planes 17–24. b runs 1..31 then 0 on the last plane. point_complete pulses once on cycle 97; load_ready returns to 1.
- Early abort: same load, terminate=1 during the 10th valid cycle (plane 4, code 01) → valid drops the next cycle, point_aborted=1 for one cycle, exactly 10 valid cycles total, no point_complete.
- Terminate on final bit: terminate=1 in valid cycle 96 → point_aborted=1, point_complete stays 0.
- Back-to-back: hold load_valid=1 with two different point pairs → second stream starts one cycle after the first ends. The second pair's bits match its own coordinates, and each stream emits exactly one completion pulse.
- Reset mid-stream: drive rst=0 asynchronously at valid cycle 40 → valid, code, q_bit, r_bit, b and both pulses go to 0 immediately; load_ready=1 after release; a fresh load streams from plane 1.
- Input stability: change q_x/r_x and pulse load_valid during STREAM → the emitted bits still reflect the originally captured values, and load_ready stays 0.

Source files
------------

// File: rtl/bdu_bit_streamer.sv
// Transmit side of the BDU bit-serial interface.
// Captures a query/reference point pair through a valid/ready handshake and
// streams both points MSB-first, one bit per cycle, interleaving the x, y and
// z axes within each bit-plane. The stream stops early on terminate.
// Every output is registered: the output logic computes the value each
// output takes after the coming edge, from the next state and next capture.

module bdu_bit_streamer #(
  parameter int B  = 32,
  parameter int BW = $clog2(B)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [B-1:0]  q_x,
  input  logic [B-1:0]  q_y,
  input  logic [B-1:0]  q_z,
  input  logic [B-1:0]  r_x,
  input  logic [B-1:0]  r_y,
  input  logic [B-1:0]  r_z,
  input  logic          terminate,
  output logic          valid,
  output logic          q_bit,
  output logic          r_bit,
  output logic [1:0]    code,
  output logic [BW-1:0] b,
  output logic          point_complete,
  output logic          point_aborted
);

  localparam int PW = (B > 1) ? $clog2(B) : 1;
  localparam logic [PW-1:0] LAST_PLANE = PW'(B - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] plane;
  logic [PW-1:0] plane_nxt;
  logic [1:0]    axis;
  logic [1:0]    axis_nxt;

  logic          load_fire;
  logic          done_fire;
  logic          abort_fire;

  logic [B-1:0]  qx_cap;
  logic [B-1:0]  qy_cap;
  logic [B-1:0]  qz_cap;
  logic [B-1:0]  rx_cap;
  logic [B-1:0]  ry_cap;
  logic [B-1:0]  rz_cap;
  logic [B-1:0]  qx_nxt;
  logic [B-1:0]  qy_nxt;
  logic [B-1:0]  qz_nxt;
  logic [B-1:0]  rx_nxt;
  logic [B-1:0]  ry_nxt;
  logic [B-1:0]  rz_nxt;

  logic [PW-1:0] bit_idx;
  logic [PW:0]   plane_inc;

  logic          load_ready_nxt;
  logic          valid_nxt;
  logic          q_bit_nxt;
  logic          r_bit_nxt;
  logic [1:0]    code_nxt;
  logic [BW-1:0] b_nxt;
  logic          point_complete_nxt;
  logic          point_aborted_nxt;

  // State, bit position and captured point pair registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      plane  <= '0;
      axis   <= 2'd0;
      qx_cap <= '0;
      qy_cap <= '0;
      qz_cap <= '0;
      rx_cap <= '0;
      ry_cap <= '0;
      rz_cap <= '0;
    end else begin
      state  <= state_nxt;
      plane  <= plane_nxt;
      axis   <= axis_nxt;
      qx_cap <= qx_nxt;
      qy_cap <= qy_nxt;
      qz_cap <= qz_nxt;
      rx_cap <= rx_nxt;
      ry_cap <= ry_nxt;
      rz_cap <= rz_nxt;
    end
  end

  // Next state: accept a load in IDLE, walk axis then plane in STREAM,
  // leave on the last bit or on terminate (terminate takes priority).
  always_comb begin
    state_nxt  = state;
    plane_nxt  = plane;
    axis_nxt   = axis;
    load_fire  = 1'b0;
    done_fire  = 1'b0;
    abort_fire = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = STREAM;
          plane_nxt = '0;
          axis_nxt  = 2'd0;
          load_fire = 1'b1;
        end
      end
      STREAM: begin
        if (terminate) begin
          state_nxt  = IDLE;
          plane_nxt  = '0;
          axis_nxt   = 2'd0;
          abort_fire = 1'b1;
        end else if (axis == 2'd2) begin
          if (plane == LAST_PLANE) begin
            state_nxt = IDLE;
            plane_nxt = '0;
            axis_nxt  = 2'd0;
            done_fire = 1'b1;
          end else begin
            axis_nxt  = 2'd0;
            plane_nxt = plane + PW'(1);
          end
        end else begin
          axis_nxt = axis + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        plane_nxt = '0;
        axis_nxt  = 2'd0;
      end
    endcase
  end

  // Capture path: the new pair is visible to the output logic at the load
  // edge so the first bit can be shown right away; otherwise hold.
  always_comb begin
    qx_nxt = qx_cap;
    qy_nxt = qy_cap;
    qz_nxt = qz_cap;
    rx_nxt = rx_cap;
    ry_nxt = ry_cap;
    rz_nxt = rz_cap;
    if (load_fire) begin
      qx_nxt = q_x;
      qy_nxt = q_y;
      qz_nxt = q_z;
      rx_nxt = r_x;
      ry_nxt = r_y;
      rz_nxt = r_z;
    end
  end

  // Output values for the coming cycle, derived from the next position.
  always_comb begin
    bit_idx            = LAST_PLANE - plane_nxt;
    plane_inc          = {1'b0, plane_nxt} + (PW + 1)'(1);
    load_ready_nxt     = 1'b1;
    valid_nxt          = 1'b0;
    code_nxt           = 2'b00;
    q_bit_nxt          = 1'b0;
    r_bit_nxt          = 1'b0;
    b_nxt              = '0;
    point_complete_nxt = done_fire;
    point_aborted_nxt  = abort_fire;
    if (state_nxt == STREAM) begin
      load_ready_nxt = 1'b0;
      valid_nxt      = 1'b1;
      code_nxt       = axis_nxt + 2'd1;
      b_nxt          = BW'(plane_inc);
      case (axis_nxt)
        2'd0: begin
          q_bit_nxt = qx_nxt[bit_idx];
          r_bit_nxt = rx_nxt[bit_idx];
        end
        2'd1: begin
          q_bit_nxt = qy_nxt[bit_idx];
          r_bit_nxt = ry_nxt[bit_idx];
        end
        2'd2: begin
          q_bit_nxt = qz_nxt[bit_idx];
          r_bit_nxt = rz_nxt[bit_idx];
        end
        default: begin
          q_bit_nxt = 1'b0;
          r_bit_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output registers; reset leaves the interface idle and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_ready     <= 1'b1;
      valid          <= 1'b0;
      q_bit          <= 1'b0;
      r_bit          <= 1'b0;
      code           <= 2'b00;
      b              <= '0;
      point_complete <= 1'b0;
      point_aborted  <= 1'b0;
    end else begin
      load_ready     <= load_ready_nxt;
      valid          <= valid_nxt;
      q_bit          <= q_bit_nxt;
      r_bit          <= r_bit_nxt;
      code           <= code_nxt;
      b              <= b_nxt;
      point_complete <= point_complete_nxt;
      point_aborted  <= point_aborted_nxt;
    end
  end

endmodule
